// File: rtl/cla_result_fifo.sv
// -----------------------------------------------------------------------------
// cla_result_fifo
//
// Output buffer for the 5-bit carry-lookahead adder. Every registered
// {cout, sum} result that the adder marks valid is captured into a small
// first-word-fall-through FIFO and handed to downstream logic over a
// valid/ready handshake. Results survive a stalled consumer until the
// buffer fills; after that, new results are dropped and stored entries
// are left untouched.
//
// Optional feature macro: CLA_FIFO_DROP_CNT_EN
//   Defined   : adds the 8-bit drop_cnt output, a saturating count of writes
//               dropped because the FIFO was full and not being popped.
//   Undefined : no drop_cnt port; dropped writes are silently discarded.
//
// Parameters
//   WIDTH  adder sum width (default 5)
//   DEPTH  number of entries, power of two, >= 2 (default 8)
//
// Ports
//   clk        in   rising-edge clock, shared with the adder
//   rst        in   asynchronous active-high reset
//   in_valid   in   adder result valid this cycle
//   in_sum     in   adder sum            [WIDTH-1:0]
//   in_cout    in   adder carry out
//   out_valid  out  head entry available
//   out_ready  in   consumer takes the head entry this cycle
//   out_data   out  head entry {cout, sum} [WIDTH:0], 0 while empty
//   full       out  FIFO holds DEPTH entries
//   empty      out  FIFO holds no entries
//   level      out  occupancy 0..DEPTH  [$clog2(DEPTH):0]
//   drop_cnt   out  saturating dropped-write count [7:0] (macro only)
// -----------------------------------------------------------------------------
module cla_result_fifo #(
    parameter  int WIDTH = 5,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
`ifdef CLA_FIFO_DROP_CNT_EN
    ,
    output logic [7:0]       drop_cnt
`endif
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH:0]  mem_q [DEPTH];

    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   rd_ptr_d;
    logic [LW-1:0]   level_q;
    logic [LW-1:0]   level_d;
    logic            full_q;
    logic            full_d;
    logic            empty_q;
    logic            empty_d;

    logic            pop;
    logic            push;
    logic [WIDTH:0]  wr_word;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    // A pop is only possible when something is stored, so out_ready while
    // empty never moves the read pointer.
    assign pop     = !empty_q && out_ready;

    // When full, a same-cycle pop frees the slot the push needs, so both
    // complete and the new entry lands behind the existing ones.
    assign push    = in_valid && (!full_q || pop);

    assign wr_word = {in_cout, in_sum};

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        // Pointers are exactly AW bits wide, so the increment wraps
        // modulo DEPTH on its own.
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // Flags are registered alongside level so the outputs come straight
        // from flops rather than from a comparator on the level register.
        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == '0);
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    // Entries are not reset: after a reset the pointers and level say the
    // FIFO is empty, and out_data is forced to 0 while empty, so stale
    // contents can never be observed.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_q == AW'(gi))) begin
                mem_q[gi] <= wr_word;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Dropped-write counter
    // -------------------------------------------------------------------------
`ifdef CLA_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt_q;
    logic [7:0] drop_cnt_d;
    logic       drop;

    // A write is lost only when full and nothing leaves this cycle.
    assign drop = in_valid && full_q && !pop;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_valid = !empty_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign level     = level_q;

    // First-word fall-through: the head entry is visible without a read
    // request; zero while empty so nothing stale leaks out.
    assign out_data  = empty_q ? '0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_cla_result_fifo.sv
// -----------------------------------------------------------------------------
// tb_cla_result_fifo
//
// Self-checking bench for cla_result_fifo. The reference is a plain queue of
// {cout, sum} words plus a saturating drop count; each cycle the bench
// decides from the queue size whether the pop/push happen, advances the
// clock, then updates the queue. Each test task compares DUT outputs with
// the reference inline. Build with +define+CLA_FIFO_DROP_CNT_EN to also
// cover the drop counter.
// -----------------------------------------------------------------------------
module tb_cla_result_fifo;

    localparam int WIDTH = 5;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic [WIDTH-1:0] in_sum    = '0;
    logic             in_cout   = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [WIDTH:0]   out_data;
    logic             full;
    logic             empty;
    logic [LW-1:0]    level;
`ifdef CLA_FIFO_DROP_CNT_EN
    logic [7:0]       drop_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model
    logic [WIDTH:0] mq[$];
    int             m_drop = 0;

    cla_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .in_cout   (in_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .full      (full),
        .empty     (empty),
        .level     (level)
`ifdef CLA_FIFO_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH:0] m_head();
        return (mq.size() != 0) ? mq[0] : '0;
    endfunction

    function automatic logic [LW-1:0] m_level();
        return LW'(mq.size());
    endfunction

    // Drive one cycle of stimulus, advance past the edge, update the model.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] s,
                         input logic c, input logic r);
        bit pop_m;
        bit push_m;
        in_valid  = v;
        in_sum    = s;
        in_cout   = c;
        out_ready = r;
        pop_m  = (mq.size() != 0) && r;
        push_m = v && ((mq.size() < DEPTH) || pop_m);
        if (v && (mq.size() == DEPTH) && !pop_m && (m_drop < 255)) m_drop++;
        @(posedge clk);
        #1;
        if (pop_m)  void'(mq.pop_front());
        if (push_m) mq.push_back({c, s});
        $display("t=%0t in_valid=%0b in={%0b,%02h} out_ready=%0b push=%0b pop=%0b -> level=%0d out_valid=%0b out_data=%02h",
                 $time, v, c, s, r, push_m, pop_m, level, out_valid, out_data);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mq.delete();
        m_drop = 0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 5'(i + 3), 1'b0, 1'b0);
        n_vec++; if (level !== 3'd3) begin n_err++; $display("FAIL reset_pre_level: got %0d want 3", level); end
        // Assert reset between edges and look immediately.
        #2 rst = 1'b1;
        #1;
        mq.delete();
        m_drop = 0;
        n_vec++; if (empty !== 1'b1)     begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_vec++; if (full !== 1'b0)      begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
        n_vec++; if (level !== '0)       begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== '0)    begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
`ifdef CLA_FIFO_DROP_CNT_EN
        n_vec++; if (drop_cnt !== 8'd0)  begin n_err++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
`endif
        #1 rst = 1'b0;
        // Reset held no edge's worth of operations: still empty after release edge.
        cycle(1'b0, '0, 1'b0, 1'b1);
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_release_empty: got %b want 1", empty); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_single();
        cycle(1'b1, 5'b00000, 1'b1, 1'b0);
        n_vec++; if (out_valid !== 1'b1)       begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
        n_vec++; if (out_data !== 6'b100000)   begin n_err++; $display("FAIL single_data: got %b want 100000", out_data); end
        n_vec++; if (level !== 4'd1)           begin n_err++; $display("FAIL single_level: got %0d want 1", level); end
        cycle(1'b0, '0, 1'b0, 1'b1);
        n_vec++; if (empty !== 1'b1)           begin n_err++; $display("FAIL single_empty: got %b want 1", empty); end
        n_vec++; if (out_data !== '0)          begin n_err++; $display("FAIL single_zero_data: got %h want 0", out_data); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_fill_overflow();
        logic [WIDTH:0] e;
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 5'(i), 1'b0, 1'b0);
        n_vec++; if (full !== 1'b1)   begin n_err++; $display("FAIL fill_full: got %b want 1", full); end
        n_vec++; if (level !== 4'd8)  begin n_err++; $display("FAIL fill_level: got %0d want 8", level); end
        cycle(1'b1, 5'b01010, 1'b0, 1'b0);
        n_vec++; if (level !== 4'd8)  begin n_err++; $display("FAIL overflow_level: got %0d want 8", level); end
        n_vec++; if (out_data !== 6'd0) begin n_err++; $display("FAIL overflow_head: got %h want 00", out_data); end
`ifdef CLA_FIFO_DROP_CNT_EN
        n_vec++; if (drop_cnt !== 8'd1) begin n_err++; $display("FAIL overflow_drop_cnt: got %0d want 1", drop_cnt); end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            e = (WIDTH + 1)'(i);
            n_vec++; if (out_data !== e) begin n_err++; $display("FAIL drain_data[%0d]: got %h want %h", i, out_data, e); end
            cycle(1'b0, '0, 1'b0, 1'b1);
        end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", empty); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_simul_full();
        int             drops_before;
        logic [WIDTH:0] last;
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 5'(i), 1'b0, 1'b0);
        drops_before = m_drop;
        cycle(1'b1, 5'b10101, 1'b0, 1'b1);
        n_vec++; if (level !== 4'd8)     begin n_err++; $display("FAIL simul_level: got %0d want 8", level); end
        n_vec++; if (out_data !== 6'd1)  begin n_err++; $display("FAIL simul_head: got %h want 01", out_data); end
        n_vec++; if (m_drop != drops_before) begin n_err++; $display("FAIL simul_model_drop: got %0d want %0d", m_drop, drops_before); end
`ifdef CLA_FIFO_DROP_CNT_EN
        n_vec++; if (drop_cnt !== 8'(drops_before)) begin n_err++; $display("FAIL simul_drop_cnt: got %0d want %0d", drop_cnt, drops_before); end
`endif
        last = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n_vec++; if (out_data !== m_head()) begin n_err++; $display("FAIL simul_drain[%0d]: got %h want %h", i, out_data, m_head()); end
            last = out_data;
            cycle(1'b0, '0, 1'b0, 1'b1);
        end
        n_vec++; if (last !== 6'b010101) begin n_err++; $display("FAIL simul_last: got %b want 010101", last); end
        n_vec++; if (empty !== 1'b1)     begin n_err++; $display("FAIL simul_empty: got %b want 1", empty); end
    endtask

    // -------------------------------------------------------------------------
    // 20 results a+b with a=i, b=1 at one per cycle. out_ready alternates
    // 1,0 for the first 12 cycles then stays high, so occupancy peaks at 7:
    // both pointers wrap more than once without any write being dropped.
    task automatic test_wrap();
        logic [WIDTH:0] sent[$];
        logic [WIDTH:0] got[$];
        logic [5:0]     tot;
        logic           r;
        int             drops_before;
        int             guard;
        drops_before = m_drop;
        for (int i = 0; i < 20; i++) begin
            tot = 6'(i + 1);
            r   = (i < 12) ? ((i % 2) == 0) : 1'b1;
            if (out_valid && r) got.push_back(out_data);
            sent.push_back({tot[5], tot[4:0]});
            cycle(1'b1, tot[4:0], tot[5], r);
            n_vec++; if (level > 4'd8 || level !== m_level()) begin n_err++; $display("FAIL wrap_level[%0d]: got %0d want %0d", i, level, m_level()); end
            n_vec++; if (out_data !== m_head()) begin n_err++; $display("FAIL wrap_head[%0d]: got %h want %h", i, out_data, m_head()); end
        end
        guard = 0;
        while (out_valid && guard < 2 * DEPTH) begin
            got.push_back(out_data);
            cycle(1'b0, '0, 1'b0, 1'b1);
            guard++;
        end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL wrap_drain_timeout: empty=%b want 1", empty); end
        n_vec++; if (got.size() != sent.size()) begin n_err++; $display("FAIL wrap_count: got %0d want %0d", got.size(), sent.size()); end
        for (int i = 0; i < sent.size() && i < got.size(); i++) begin
            n_vec++; if (got[i] !== sent[i]) begin n_err++; $display("FAIL wrap_order[%0d]: got %h want %h", i, got[i], sent[i]); end
        end
        n_vec++; if (m_drop != drops_before) begin n_err++; $display("FAIL wrap_model_drop: got %0d want %0d", m_drop, drops_before); end
`ifdef CLA_FIFO_DROP_CNT_EN
        n_vec++; if (drop_cnt !== 8'(drops_before)) begin n_err++; $display("FAIL wrap_drop_cnt: got %0d want %0d", drop_cnt, drops_before); end
`endif
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid();
        logic [WIDTH-1:0] rs;
        logic             rc;
        for (int i = 0; i < 5; i++) cycle(1'b1, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0);
        n_vec++; if (level !== 4'd5) begin n_err++; $display("FAIL rmid_level: got %0d want 5", level); end
        #2 rst = 1'b1;
        #1;
        mq.delete();
        m_drop = 0;
        n_vec++; if (empty !== 1'b1)     begin n_err++; $display("FAIL rmid_empty: got %b want 1", empty); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
        n_vec++; if (level !== '0)       begin n_err++; $display("FAIL rmid_level0: got %0d want 0", level); end
        #1 rst = 1'b0;
        rs = 5'($urandom_range(0, 31));
        rc = 1'($urandom_range(0, 1));
        cycle(1'b1, rs, rc, 1'b0);
        n_vec++; if (out_valid !== 1'b1)    begin n_err++; $display("FAIL rmid_first_valid: got %b want 1", out_valid); end
        n_vec++; if (out_data !== {rc, rs}) begin n_err++; $display("FAIL rmid_first_data: got %h want %h", out_data, {rc, rs}); end
        n_vec++; if (level !== 4'd1)        begin n_err++; $display("FAIL rmid_first_level: got %0d want 1", level); end
        cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_random();
        logic v;
        logic r;
        for (int i = 0; i < 300; i++) begin
            // Phases bias the stream toward filling or draining.
            v = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 80 : 35));
            r = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 35 : 80));
            cycle(v, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), r);
            n_vec++; if (out_valid !== (mq.size() != 0)) begin n_err++; $display("FAIL rand_valid[%0d]: got %b want %b", i, out_valid, mq.size() != 0); end
            n_vec++; if (out_data !== m_head())  begin n_err++; $display("FAIL rand_data[%0d]: got %h want %h", i, out_data, m_head()); end
            n_vec++; if (level !== m_level())    begin n_err++; $display("FAIL rand_level[%0d]: got %0d want %0d", i, level, m_level()); end
            n_vec++; if (full !== (mq.size() == DEPTH)) begin n_err++; $display("FAIL rand_full[%0d]: got %b want %b", i, full, mq.size() == DEPTH); end
            n_vec++; if (empty !== (mq.size() == 0))    begin n_err++; $display("FAIL rand_empty[%0d]: got %b want %b", i, empty, mq.size() == 0); end
`ifdef CLA_FIFO_DROP_CNT_EN
            n_vec++; if (drop_cnt !== 8'(m_drop)) begin n_err++; $display("FAIL rand_drop_cnt[%0d]: got %0d want %0d", i, drop_cnt, m_drop); end
`endif
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_simul_full();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
